// File: rtl/shift_sub_divider_if.sv
// Request/response bundle for the shift-subtract divider.
// The requester drives start and operands; the divider answers with
// ready/done and holds the last result until the next done.
interface shift_sub_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one shift-and-subtract step per clock,
// WIDTH steps per operation. The trial subtract is an explicit ripple of
// full adders computing R_shifted + ~{0,D} + 1, and its carry out decides
// whether the difference is kept (carry=1 means no borrow).
// A zero divisor skips the iterations and reports all-ones / dividend.
module shift_sub_divider #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                reset,
    shift_sub_divider_if.slave bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [2*WIDTH:0] rq_shift;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // Shift {R,Q} left by one and ripple the trial subtract through WIDTH+1 full adders.
    always_comb begin
        rq_shift  = {rem_q, quo_q} << 1;
        rem_shift = rq_shift[2*WIDTH:WIDTH];
        quo_shift = rq_shift[WIDTH-1:0];
        sub_b     = ~{1'b0, den_q};
        carry     = 1'b1;
        diff      = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = rem_shift[i] ^ sub_b[i] ^ carry;
            carry   = (rem_shift[i] & sub_b[i]) | (carry & (rem_shift[i] ^ sub_b[i]));
        end
        rem_next = carry ? diff : rem_shift;
        quo_next = quo_shift | {{(WIDTH-1){1'b0}}, carry};
    end

    // Next-state and datapath updates for IDLE/RUN/DONE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        den_d         = den_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    quo_d = bus.dividend;
                    den_d = bus.divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        state_d       = S_DONE;
                        quotient_d    = '1;
                        remainder_d   = bus.dividend;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d       = S_DONE;
                    quotient_d    = quo_next;
                    remainder_d   = rem_next[WIDTH-1:0];
                    div_by_zero_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            den_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            den_q         <= den_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.ready       = (state_q == S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule
